sr_latch_sequencer: RTL
=======================

Name: sr_latch_sequencer

Overview:
- Sequences a shared gate-level SR latch (inputs R, S; outputs Q, NQ) on behalf of two independent requesters, A and B.
- Arbitrates between them round-robin and drives S or R with a timed pulse, followed by a settle window.
- Checks the latch's Q/NQ feedback against the expected result and acknowledges the requester.
- Guarantees the forbidden S=R=1 combination is never driven.

Parameters:
- PULSE_LEN, 2, cycles S or R is held high per operation (legal range 1..15).
- SETTLE_LEN, 1, cycles with S=R=0 before Q/NQ is sampled (legal range 1..15).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A operation request, level, held until ack_a.
- op_a  input  1  requester A operation: 1=set, 0=reset. Stable while req_a=1.
- req_b  input  1  requester B operation request, same rules as req_a.
- op_b  input  1  requester B operation, same rules as op_a.
- q_in  input  1  latch Q feedback.
- nq_in  input  1  latch NQ feedback.
- s_out  output  1  drives latch S.
- r_out  output  1  drives latch R.
- ack_a  output  1  one-cycle completion pulse to A.
- ack_b  output  1  one-cycle completion pulse to B.
- err  output  1  valid with ack: feedback mismatch or Q==NQ.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; s_out=r_out=ack_a=ack_b=err=busy=0; round-robin pointer=A (A has priority first); counter=0.
- States: IDLE, PULSE, SETTLE, CHECK.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the pointer side.
  - On grant, latch the owner and op, load counter=PULSE_LEN-1, go to PULSE.
  - Requests are sampled only in IDLE.
- PULSE:
  - s_out=op, r_out=~op, both registered. Each is high for exactly PULSE_LEN cycles.
  - The counter decrements; at 0, load SETTLE_LEN-1 and go to SETTLE.
- SETTLE:
  - s_out=r_out=0.
  - The counter decrements; at 0, go to CHECK.
- CHECK (one cycle):
  - Sample q_in/nq_in.
  - Expected result is q_in==op and nq_in==~op; otherwise err=1.
  - Pulse the owner's ack for exactly this cycle; err is valid only in this cycle and 0 elsewhere.
  - Pointer moves to the side opposite the owner.
  - Next state is IDLE.
- Latency: grant to ack = PULSE_LEN+SETTLE_LEN+1 cycles after the IDLE grant cycle.
  - Defaults: ack arrives 4 cycles after the grant edge.
- Throughput: at most one operation per PULSE_LEN+SETTLE_LEN+2 cycles.
  - A requester still high the cycle after its ack is treated as a new request.
- Safety: s_out and r_out are never both 1 in any cycle, including reset entry and exit. Outputs are registered, so there are no glitches.
- Dropped request: if the owner deasserts req mid-operation, the operation still completes and ack is still issued.
- Reset mid-operation: all outputs go to 0 immediately (async); the operation is abandoned with no ack.
- Simultaneous requests: when both requesters are held continuously, grants strictly alternate.
- Unused/illegal parameter values (0) are not supported; the implementation flags them with a compile-time check.

Test Plan:
- Reset, then req_a=1, op_a=1 with the latch model attached:
  - Required: s_out=1 for 2 cycles, then 1 settle cycle, then ack_a=1 with err=0 and q_in=1.
  - Required: busy high for 4 cycles and r_out=0 throughout.
- req_a and req_b both held, op_a=1, op_b=0:
  - Required: grants alternate A, B, A, B.
  - Required: Q toggles 1, 0, 1, 0; each ack is one cycle wide.
- Latch model stuck at Q=0, request set:
  - Required: ack_a with err=1.
  - Separate case: Q=NQ=1 feedback yields err=1.
- rst_n pulsed low during PULSE:
  - Required: s_out=r_out=0 asynchronously; no ack; state IDLE.
  - Required: a subsequent request completes normally.
- req_b dropped one cycle after grant:
  - Required: the operation runs to completion and ack_b is still asserted.
- Every run asserts each cycle that s_out&r_out==0.
- PULSE_LEN=3, SETTLE_LEN=2 parameter override:
  - Required: the S pulse is 3 cycles wide and ack arrives 6 cycles after grant.

Source files
------------

// File: rtl/sr_latch_sequencer_if.sv
// Bus between the SR latch sequencer and its environment: two requesters plus
// the drive/feedback pins of the shared latch.
`timescale 1ns/1ps

interface sr_latch_sequencer_if;
  logic req_a;
  logic op_a;
  logic req_b;
  logic op_b;
  logic q_in;
  logic nq_in;
  logic s_out;
  logic r_out;
  logic ack_a;
  logic ack_b;
  logic err;
  logic busy;

  // The master is the environment side: both requesters and the latch feedback.
  modport master (
    output req_a, op_a, req_b, op_b, q_in, nq_in,
    input  s_out, r_out, ack_a, ack_b, err, busy
  );

  modport slave (
    input  req_a, op_a, req_b, op_b, q_in, nq_in,
    output s_out, r_out, ack_a, ack_b, err, busy
  );
endinterface

// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer for a shared SR latch: timed S/R pulse, settle window,
// Q/NQ feedback check and a one-cycle acknowledge to the owning requester.
`timescale 1ns/1ps

module sr_latch_sequencer #(
  parameter int unsigned PULSE_LEN  = 2,
  parameter int unsigned SETTLE_LEN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sr_latch_sequencer_if.slave   bus
);

  localparam int unsigned CNT_W = 4;

  if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : g_bad_pulse_len
    $error("sr_latch_sequencer: PULSE_LEN must be in 1..15");
  end
  if (SETTLE_LEN < 1 || SETTLE_LEN > 15) begin : g_bad_settle_len
    $error("sr_latch_sequencer: SETTLE_LEN must be in 1..15");
  end

  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_e;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  side_e            owner_q, owner_d;
  side_e            ptr_q,   ptr_d;
  logic             op_q,    op_d;

  logic s_q,     s_d;
  logic r_q,     r_d;
  logic ack_a_q, ack_a_d;
  logic ack_b_q, ack_b_d;
  logic busy_q,  busy_d;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment so all flops update
  // together from the values computed in the combinational processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= SIDE_A;
      ptr_q   <= SIDE_A;
      op_q    <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    op_d    = op_q;

    case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          if (bus.req_a && bus.req_b) begin
            owner_d = ptr_q;
          end else if (bus.req_b) begin
            owner_d = SIDE_B;
          end else begin
            owner_d = SIDE_A;
          end
          op_d    = (owner_d == SIDE_B) ? bus.op_b : bus.op_a;
          cnt_d   = PULSE_LOAD;
          state_d = PULSE;
        end
      end

      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      CHECK: begin
        // Hand priority to the other side so continuous contention alternates.
        ptr_d   = (owner_q == SIDE_A) ? SIDE_B : SIDE_A;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: values for the output registers, decoded from the next state
  // so s_out/r_out/ack/busy line up exactly with the state they belong to.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_d     = (state_d == PULSE) &&  op_d;
    r_d     = (state_d == PULSE) && !op_d;
    busy_d  = (state_d != IDLE);
    ack_a_d = (state_d == CHECK) && (owner_d == SIDE_A);
    ack_b_d = (state_d == CHECK) && (owner_d == SIDE_B);
  end

  // s_out and r_out come from one op bit through complementary terms, so the
  // forbidden S=R=1 drive cannot occur, and reset clears both at once.
  assign bus.s_out = s_q;
  assign bus.r_out = r_q;
  assign bus.ack_a = ack_a_q;
  assign bus.ack_b = ack_b_q;
  assign bus.busy  = busy_q;

  // Feedback is judged during the CHECK cycle itself: Q must equal op and NQ
  // must be its complement.
  assign bus.err = (state_q == CHECK) &&
                   ((bus.q_in != op_q) || (bus.nq_in == op_q));

endmodule
